// File: rtl/mm_ctrl.sv
// Matrix-multiply controller: streams A then B into a helper, then issues one compute per C element, row-major.
// Latency: C result one cycle after its COMPUTE; out_ready low holds WAIT; cycle_count built only with MM_CTRL_CYCCNT_EN.
module mm_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int N              = 4,
  parameter int OUT_DATA_WIDTH = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [N-1:0]              dim_m,
  input  logic [N-1:0]              dim_k,
  input  logic [N-1:0]              dim_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_DATA_WIDTH-1:0] out_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [15:0]               cycle_count,
  output logic                      hp_wr_enable,
  output logic                      hp_compute_enable,
  output logic [DATA_WIDTH-1:0]     hp_in_data,
  output logic [N-1:0]              hp_i,
  output logic [N-1:0]              hp_j,
  output logic                      hp_is_first_mat,
  output logic [N-1:0]              hp_match_dim,
  input  logic [OUT_DATA_WIDTH-1:0] hp_out_data
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, WAIT, DONE, ERR} state_t;

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] NMAX  = N[N-1:0];

  state_t       state, state_n;
  logic [N-1:0] m_q, k_q, n_q;
  logic [N-1:0] i_q, j_q, i_n, j_n;
  logic [N-1:0] rows, cols, adv_i, adv_j;
  logic         drain_q, drain_n;
  logic         xfer, last_elem, dims_ok;

  always_comb begin
    rows = m_q;
    cols = k_q;
    case (state)
      LOAD_B:        begin rows = k_q; cols = n_q; end
      COMPUTE, WAIT: begin rows = m_q; cols = n_q; end
      default: ;
    endcase
  end

  assign dims_ok   = (dim_m != '0) && (dim_m <= NMAX) && (dim_k != '0) && (dim_k <= NMAX) &&
                     (dim_n != '0) && (dim_n <= NMAX);
  assign last_elem = (i_q == rows - ONE_N) && (j_q == cols - ONE_N);
  assign adv_i     = (j_q == cols - ONE_N) ? i_q + ONE_N : i_q;
  assign adv_j     = (j_q == cols - ONE_N) ? '0 : j_q + ONE_N;

  // The cycle after the last B element carries its helper write, so the load
  // stage drains one cycle before COMPUTE to keep write and compute disjoint.
  assign in_ready  = ((state == LOAD_A) || (state == LOAD_B)) && !drain_q;
  assign xfer      = in_ready && in_valid;
  assign out_valid = (state == WAIT);
  assign out_data  = hp_out_data;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = (state == ERR);

  always_comb begin
    state_n = state;
    i_n     = i_q;
    j_n     = j_q;
    drain_n = drain_q;
    case (state)
      IDLE: begin
        i_n     = '0;
        j_n     = '0;
        drain_n = 1'b0;
        if (start) state_n = dims_ok ? LOAD_A : ERR;
      end
      LOAD_A: begin
        if (xfer) begin
          if (last_elem) begin
            state_n = LOAD_B;
            i_n     = '0;
            j_n     = '0;
          end else begin
            i_n = adv_i;
            j_n = adv_j;
          end
        end
      end
      LOAD_B: begin
        if (drain_q) begin
          state_n = COMPUTE;
          drain_n = 1'b0;
        end else if (xfer) begin
          if (last_elem) begin
            drain_n = 1'b1;
            i_n     = '0;
            j_n     = '0;
          end else begin
            i_n = adv_i;
            j_n = adv_j;
          end
        end
      end
      COMPUTE: state_n = WAIT;
      WAIT: begin
        if (out_ready) begin
          if (last_elem) begin
            state_n = DONE;
          end else begin
            state_n = COMPUTE;
            i_n     = adv_i;
            j_n     = adv_j;
          end
        end
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q               <= '0;
      k_q               <= '0;
      n_q               <= '0;
      i_q               <= '0;
      j_q               <= '0;
      drain_q           <= 1'b0;
      hp_wr_enable      <= 1'b0;
      hp_compute_enable <= 1'b0;
      hp_in_data        <= '0;
      hp_i              <= '0;
      hp_j              <= '0;
      hp_is_first_mat   <= 1'b0;
      hp_match_dim      <= '0;
    end else begin
      i_q               <= i_n;
      j_q               <= j_n;
      drain_q           <= drain_n;
      hp_wr_enable      <= xfer;
      hp_compute_enable <= (state_n == COMPUTE);
      if (state == IDLE && start) begin
        m_q <= dim_m;
        k_q <= dim_k;
        n_q <= dim_n;
      end
      if (xfer) begin
        hp_in_data      <= in_data;
        hp_i            <= i_q;
        hp_j            <= j_q;
        hp_is_first_mat <= (state == LOAD_A);
      end else if (state_n == COMPUTE) begin
        hp_i         <= i_n;
        hp_j         <= j_n;
        hp_match_dim <= k_q;
      end
    end
  end

`ifdef MM_CTRL_CYCCNT_EN
  logic [15:0] cyc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         cyc_q <= '0;
    else if (state == IDLE && start)    cyc_q <= '0;
    else if (busy && cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = 16'h0000;
`endif

endmodule
